// File: rtl/alu_issue_unit_if.sv
// Signal bundle between the controller/ALU environment and alu_issue_unit.
// The slave modport is the issue unit's view; the master modport is the surrounding environment.
interface alu_issue_unit_if;
  logic        start;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt_in;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero_flag;
  logic        illegal;

  modport slave (
    input  start, opcode, funct, shamt_in, rs_data, rt_data, imm, ALUResult, Zero,
    output ALUOperation, A, B, shamt, busy, done, result, zero_flag, illegal
  );

  modport master (
    output start, opcode, funct, shamt_in, rs_data, rt_data, imm, ALUResult, Zero,
    input  ALUOperation, A, B, shamt, busy, done, result, zero_flag, illegal
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Multicycle ALU issue unit: decodes opcode/funct, holds ALU operands for EXEC_CYCLES,
// captures ALUResult/Zero and reports completion with a registered done/illegal pulse.
module alu_issue_unit #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  alu_issue_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  opcode_q, opcode_d, funct_q, funct_d;
  logic [4:0]  shin_q, shin_d, shamt_q, shamt_d;
  logic [31:0] rs_q, rs_d, rt_q, rt_d;
  logic [15:0] imm_q, imm_d;
  logic [3:0]  aluop_q, aluop_d, cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic        zero_q, zero_d, done_q, done_d, illegal_q, illegal_d, ill_q, ill_d;

  logic [3:0]  dec_op;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_sh;
  logic        dec_ill;

  // Combinational decode of the latched instruction fields.
  always_comb begin
    dec_op  = 4'b1111;
    dec_a   = '0;
    dec_b   = '0;
    dec_sh  = '0;
    dec_ill = 1'b0;
    case (opcode_q)
      6'h00: begin
        dec_a  = rs_q;
        dec_b  = rt_q;
        dec_sh = shin_q;
        case (funct_q)
          6'h24:   dec_op = 4'b0000;
          6'h25:   dec_op = 4'b0001;
          6'h27:   dec_op = 4'b0010;
          6'h20:   dec_op = 4'b0011;
          6'h22:   dec_op = 4'b0100;
          6'h00:   begin dec_op = 4'b0101; dec_a = rt_q; end
          6'h02:   begin dec_op = 4'b0110; dec_a = rt_q; end
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08: begin dec_op = 4'b1110; dec_a = rs_q; dec_b = {{16{imm_q[15]}}, imm_q}; end
      6'h0D: begin dec_op = 4'b1100; dec_a = rs_q; dec_b = {16'h0000, imm_q}; end
      6'h0F: begin dec_op = 4'b1101; dec_a = rs_q; dec_b = {16'h0000, imm_q}; end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op = 4'b1111;
      dec_a  = '0;
      dec_b  = '0;
      dec_sh = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    shin_d    = shin_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    imm_d     = imm_q;
    aluop_d   = aluop_q;
    a_d       = a_q;
    b_d       = b_q;
    shamt_d   = shamt_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ill_d     = ill_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opcode_d = bus.opcode;
          funct_d  = bus.funct;
          shin_d   = bus.shamt_in;
          rs_d     = bus.rs_data;
          rt_d     = bus.rt_data;
          imm_d    = bus.imm;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        aluop_d = dec_op;
        a_d     = dec_a;
        b_d     = dec_b;
        shamt_d = dec_sh;
        ill_d   = dec_ill;
        if (dec_ill) begin
          state_d = DONE;
        end else begin
          cnt_d   = 4'(EXEC_CYCLES - 1);
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        if (cnt_q == 4'd0) begin
          result_d = bus.ALUResult;
          zero_d   = bus.Zero;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // The pulse is registered here, so it is visible in the first IDLE cycle.
        done_d    = 1'b1;
        illegal_d = ill_q;
        if (ill_q) begin
          result_d = '0;
          zero_d   = 1'b0;
        end
        aluop_d = 4'b1111;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      funct_q   <= '0;
      shin_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      aluop_q   <= 4'b1111;
      a_q       <= '0;
      b_q       <= '0;
      shamt_q   <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ill_q     <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      shin_q    <= shin_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      imm_q     <= imm_d;
      aluop_q   <= aluop_d;
      a_q       <= a_d;
      b_q       <= b_d;
      shamt_q   <= shamt_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ill_q     <= ill_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.ALUOperation = aluop_q;
  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.shamt        = shamt_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.illegal      = illegal_q;
  assign bus.result       = result_q;
  assign bus.zero_flag    = zero_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: table of directed instructions on an EXEC_CYCLES=1 unit,
// plus hand sequences for dropped starts and reset mid-EXECUTE on an EXEC_CYCLES=3 unit.
module tb_alu_issue_unit;

  logic clk = 1'b0;
  logic reset1, reset3;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_unit_if bus1();
  alu_issue_unit_if bus3();

  alu_issue_unit #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));
  alu_issue_unit #(.EXEC_CYCLES(3)) dut3 (.clk(clk), .reset(reset3), .bus(bus3));

  // Behavioural ALU standing in for the datapath ALU.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return ~(a | b);
      4'b0011: return a + b;
      4'b0100: return a - b;
      4'b0101: return a << sh;
      4'b0110: return a >> sh;
      4'b1110: return a + b;
      4'b1100: return a | b;
      4'b1101: return b << 16;
      default: return 32'h0;
    endcase
  endfunction

  assign bus1.ALUResult = alu_model(bus1.ALUOperation, bus1.A, bus1.B, bus1.shamt);
  assign bus1.Zero      = (bus1.ALUResult == 32'h0);
  assign bus3.ALUResult = alu_model(bus3.ALUOperation, bus3.A, bus3.B, bus3.shamt);
  assign bus3.Zero      = (bus3.ALUResult == 32'h0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh_in;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [3:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [4:0]  e_sh;
    logic [31:0] e_res;
    logic        e_z;
    logic        e_ill;
  } vec_t;

  vec_t vecs[13];

  task automatic drive1(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
    bus1.opcode = opc; bus1.funct = fn; bus1.shamt_in = sh;
    bus1.rs_data = rs; bus1.rt_data = rt; bus1.imm = imm;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    drive1(v.opc, v.fn, v.sh_in, v.rs, v.rt, v.imm);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    chk({tag, "_busy_dec"}, 32'(bus1.busy), 32'd1);
    chk({tag, "_done_low"}, 32'(bus1.done), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_aluop"}, 32'(bus1.ALUOperation), 32'(v.e_op));
    chk({tag, "_A"}, bus1.A, v.e_a);
    chk({tag, "_B"}, bus1.B, v.e_b);
    chk({tag, "_shamt"}, 32'(bus1.shamt), 32'(v.e_sh));
    lat = 1;
    while (bus1.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), v.e_ill ? 32'd2 : 32'd3);
    chk({tag, "_result"}, bus1.result, v.e_res);
    chk({tag, "_zero"}, 32'(bus1.zero_flag), 32'(v.e_z));
    chk({tag, "_illegal"}, 32'(bus1.illegal), 32'(v.e_ill));
    chk({tag, "_busy_idle"}, 32'(bus1.busy), 32'd0);
    chk({tag, "_aluop_idle"}, 32'(bus1.ALUOperation), 32'hF);
  endtask

  initial begin
    int lat;
    int dcount;
    reset1 = 1'b0; reset3 = 1'b0;
    bus1.start = 1'b0; drive1(6'h0, 6'h0, 5'h0, 32'h0, 32'h0, 16'h0);
    bus3.start = 1'b0; bus3.opcode = 6'h0; bus3.funct = 6'h20; bus3.shamt_in = 5'h0;
    bus3.rs_data = 32'h7; bus3.rt_data = 32'h1; bus3.imm = 16'h0;

    vecs[0]  = '{6'h00, 6'h20, 5'd5,  32'h5,        32'hFFFFFFFB, 16'h0000, 4'h3, 32'h5,        32'hFFFFFFFB, 5'd5,  32'h0,        1'b1, 1'b0};
    vecs[1]  = '{6'h08, 6'h00, 5'd7,  32'h10,       32'hABCD,     16'hFFF0, 4'hE, 32'h10,       32'hFFFFFFF0, 5'd0,  32'h0,        1'b1, 1'b0};
    vecs[2]  = '{6'h0F, 6'h00, 5'd0,  32'h0,        32'h0,        16'h1234, 4'hD, 32'h0,        32'h1234,     5'd0,  32'h12340000, 1'b0, 1'b0};
    vecs[3]  = '{6'h0D, 6'h00, 5'd0,  32'h12340000, 32'h0,        16'h5678, 4'hC, 32'h12340000, 32'h5678,     5'd0,  32'h12345678, 1'b0, 1'b0};
    vecs[4]  = '{6'h00, 6'h00, 5'd31, 32'hDEAD,     32'h1,        16'h0000, 4'h5, 32'h1,        32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0};
    vecs[5]  = '{6'h00, 6'h02, 5'd4,  32'h7,        32'h80000000, 16'h0000, 4'h6, 32'h80000000, 32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0};
    vecs[6]  = '{6'h00, 6'h24, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 16'h0000, 4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
    vecs[7]  = '{6'h00, 6'h25, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 16'h0000, 4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[8]  = '{6'h00, 6'h27, 5'd0,  32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0000, 4'h2, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  32'h0,        1'b1, 1'b0};
    vecs[9]  = '{6'h00, 6'h22, 5'd0,  32'h10,       32'h3,        16'h0000, 4'h4, 32'h10,       32'h3,        5'd0,  32'hD,        1'b0, 1'b0};
    vecs[10] = '{6'h00, 6'h3F, 5'd3,  32'h5,        32'h6,        16'h0000, 4'hF, 32'h0,        32'h0,        5'd0,  32'h0,        1'b0, 1'b1};
    vecs[11] = '{6'h3F, 6'h20, 5'd0,  32'h5,        32'h6,        16'h0001, 4'hF, 32'h0,        32'h0,        5'd0,  32'h0,        1'b0, 1'b1};
    vecs[12] = '{6'h0D, 6'h00, 5'd0,  32'h0,        32'h0,        16'h8000, 4'hC, 32'h0,        32'h00008000, 5'd0,  32'h00008000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_aluop", 32'(bus1.ALUOperation), 32'hF);
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    chk("rst_done", 32'(bus1.done), 32'd0);
    chk("rst_result", bus1.result, 32'h0);
    chk("rst_A", bus1.A, 32'h0);
    @(negedge clk);
    reset1 = 1'b1; reset3 = 1'b1;
    @(posedge clk); #1;

    // Back-to-back issue: each vector starts in the cycle its predecessor's done is high.
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Start held high through DECODE and DONE of an illegal op must not queue a second op.
    drive1(6'h3F, 6'h00, 5'd0, 32'h1, 32'h2, 16'h0);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    chk("ign_done", 32'(bus1.done), 32'd1);
    chk("ign_illegal", 32'(bus1.illegal), 32'd1);
    chk("ign_result", bus1.result, 32'h0);
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus1.done === 1'b1 || bus1.busy === 1'b1) dcount++;
    end
    chk("ign_no_extra", 32'(dcount), 32'd0);

    // EXEC_CYCLES=3 unit: full ADD to check the longer latency.
    bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    lat = 0;
    while (bus3.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("e3_latency", 32'(lat), 32'd5);
    chk("e3_result", bus3.result, 32'h8);

    // Second ADD aborted by reset while in EXECUTE.
    bus3.rs_data = 32'h20; bus3.rt_data = 32'h2;
    bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("e3_busy_exec", 32'(bus3.busy), 32'd1);
    chk("e3_aluop_exec", 32'(bus3.ALUOperation), 32'h3);
    reset3 = 1'b0;
    #1;
    chk("e3_rst_busy", 32'(bus3.busy), 32'd0);
    chk("e3_rst_aluop", 32'(bus3.ALUOperation), 32'hF);
    chk("e3_rst_result", bus3.result, 32'h0);
    chk("e3_rst_B", bus3.B, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset3 = 1'b1;
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus3.done === 1'b1) dcount++;
    end
    chk("e3_rst_nodone", 32'(dcount), 32'd0);
    chk("e3_rst_idle", 32'(bus3.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Multicycle initiator that decodes an instruction's opcode/funct into the 4-bit ALUOperation code the datapath ALU consumes.
- Drives the ALU operands A, B and shamt, holds them stable for a programmable execute window, then captures ALUResult/Zero.
- Returns the captured result to the controller through a start/done handshake.
- Sits between the multicycle control FSM/register file and the combinational ALU.

Parameters:
- EXEC_CYCLES, 1, number of cycles ALU inputs are held stable before capture (1..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- opcode  input  6  instruction[31:26]
- funct  input  6  instruction[5:0]
- shamt_in  input  5  instruction[10:6]
- rs_data  input  32  register rs value
- rt_data  input  32  register rt value
- imm  input  16  instruction[15:0]
- ALUOperation  output  4  op code to ALU
- A  output  32  ALU operand A
- B  output  32  ALU operand B
- shamt  output  5  ALU shift amount
- ALUResult  input  32  from ALU
- Zero  input  1  from ALU
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- result  output  32  captured result, held until next capture
- zero_flag  output  1  captured Zero, held
- illegal  output  1  one-cycle pulse coincident with done for undecodable instruction

Behaviour:
- Reset (reset=0, async): state IDLE; ALUOperation=4'b1111; A=B=0; shamt=0; result=0; zero_flag=0; done=0; illegal=0; busy=0; exec counter=0.
- Reset mid-operation aborts the instruction; no done pulse.
- States: IDLE, DECODE, EXECUTE, DONE.
- IDLE: on start=1, register opcode, funct, shamt_in, rs_data, rt_data, imm and go to DECODE. start in any other state is ignored and not queued.
- DECODE (1 cycle): register ALUOperation, A, B and shamt from the latched fields.
  - Valid instruction: load counter with EXEC_CYCLES-1 and go to EXECUTE.
  - Illegal instruction: go directly to DONE with illegal flagged.
- Decode table, R-type (opcode 0x00), A=rs, B=rt, shamt=shamt_in:
  - funct 0x24 AND -> 0000
  - funct 0x25 OR -> 0001
  - funct 0x27 NOR -> 0010
  - funct 0x20 ADD -> 0011
  - funct 0x22 SUB -> 0100
  - funct 0x00 SLL -> 0101, A=rt
  - funct 0x02 SRL -> 0110, A=rt
- Decode table, I-type, A=rs, shamt=0:
  - ADDI 0x08 -> 1110, B=sign-extended imm
  - ORI 0x0D -> 1100, B=zero-extended imm
  - LUI 0x0F -> 1101, B=zero-extended imm
- Any other opcode/funct is illegal: ALUOperation=1111, A=B=0.
- EXECUTE: ALU inputs held constant. Decrement the counter each cycle. When counter==0, capture result<=ALUResult and zero_flag<=Zero, then go to DONE.
- DONE (1 cycle): done=1; illegal=1 if the instruction was illegal. For an illegal instruction, result<=0 and zero_flag<=0 (ALU not sampled). Then go to IDLE, and ALUOperation returns to 1111.
- Latency: start sampled at edge N gives done high during the cycle after edge N+2+EXEC_CYCLES. Illegal: done after edge N+2.
- Back-to-back: start high in the cycle DONE returns to IDLE is accepted on the next edge. Minimum issue interval is 3+EXEC_CYCLES cycles.
- result/zero_flag change only at capture; they are stable through DONE and IDLE.
- Arithmetic is entirely in the ALU. This block performs only the 16->32 extension; no overflow detection.

Test Plan:
- Reset values: assert reset low mid-EXECUTE with EXEC_CYCLES=3 -> busy=0, done never pulses, ALUOperation=1111, result=0.
- ADD: rs=0x00000005, rt=0xFFFFFFFB, opcode 0, funct 0x20, EXEC_CYCLES=1 -> ALUOperation=0011 during EXECUTE; done 3 cycles after start edge; result=0, zero_flag=1.
- ADDI sign extension: rs=0x10, imm=0xFFF0 -> B=0xFFFFFFF0, ALUOperation=1110, result=0x00000000, zero_flag=1.
- LUI/ORI pair: LUI imm=0x1234 -> result 0x12340000. Then ORI with rs=0x12340000, imm=0x5678 -> result 0x12345678, zero_flag=0.
- SLL: rt=0x00000001, shamt_in=31 -> A=0x1, shamt=31, result 0x80000000.
- Illegal plus ignored start: opcode 0x3F -> done and illegal pulse together 2 cycles after the start edge, result=0. A start pulse asserted while busy is dropped, with no extra done.
